// File: rtl/cmos_cap_pkg.sv
// cmos_cap_pkg -- shared types and sizing helpers for the CMOS capture block.
//   cap_state_e : capture FSM state
//   PH_W        : byte-phase counter width (up to 4 bytes per pixel)
//   cnt_w()     : width of a counter that must hold n+1 (saturation headroom)
//   X_W_DEF / Y_W_DEF : counter widths for the default 1280x720 geometry
package cmos_cap_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    SKIP    = 2'd2,
    ACTIVE  = 2'd3
  } cap_state_e;

  localparam int PH_W        = 2;
  localparam int H_PIX_DEF   = 1280;
  localparam int V_LINES_DEF = 720;

  // Counters saturate at n+1 so an over-long line can never alias to n.
  function automatic int cnt_w(input int n);
    return $clog2(n + 2);
  endfunction

  localparam int X_W_DEF = $clog2(H_PIX_DEF + 2);
  localparam int Y_W_DEF = $clog2(V_LINES_DEF + 2);

endpackage

// File: rtl/cmos_pix_pack.sv
// cmos_pix_pack -- assembles camera bytes into pixels, MSB (first byte) on top.
//   i_href/i_href_rise : registered line-valid and its rising edge (phase reset)
//   i_din              : registered camera byte
//   i_keep             : pixel completing this cycle is to be emitted
//   o_done             : a pixel completes this cycle (combinational)
//   o_mid              : a partial pixel is pending
//   o_pix / o_vld      : registered packed pixel and emit strobe
module cmos_pix_pack
  import cmos_cap_pkg::*;
#(
  parameter int DIN_W         = 8,
  parameter int BYTES_PER_PIX = 2
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_href,
  input  logic                             i_href_rise,
  input  logic [DIN_W-1:0]                 i_din,
  input  logic                             i_keep,
  output logic                             o_done,
  output logic                             o_mid,
  output logic [DIN_W*BYTES_PER_PIX-1:0]   o_pix,
  output logic                             o_vld
);
  localparam int PIX_W = DIN_W * BYTES_PER_PIX;

  logic [PH_W-1:0]  r_phase, w_phase;
  logic [PIX_W-1:0] r_acc, w_acc, w_pix, r_pix;
  logic             r_vld;

  always_comb begin
    w_phase = i_href_rise ? '0 : r_phase;
    w_acc   = (w_phase == '0) ? '0 : r_acc;
    w_pix   = (w_acc << DIN_W) | PIX_W'(i_din);
    o_done  = i_href && (w_phase == PH_W'(BYTES_PER_PIX - 1));
  end

  // Still holds the partial count in the first cycle after href falls.
  assign o_mid = (r_phase != '0);
  assign o_pix = r_pix;
  assign o_vld = r_vld;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_phase <= '0;
      r_acc   <= '0;
      r_pix   <= '0;
      r_vld   <= 1'b0;
    end else begin
      if (!i_href || o_done) r_phase <= '0;
      else                   r_phase <= w_phase + PH_W'(1);
      if (i_href) r_acc <= w_pix;
      if (o_done) r_pix <= w_pix;
      r_vld <= o_done & i_keep;
    end
  end

endmodule

// File: rtl/cmos_capture_win.sv
// cmos_capture_win -- CMOS camera capture with frame skip and optional crop.
//   i_clk, i_rst_n            : pixel clock, async active-low reset
//   i_vsync, i_href, i_din    : camera sync / line valid / byte
//   i_enable                  : capture enable (drop honoured at vsync rise)
//   o_dout, o_dout_vld        : packed pixel and strobe
//   o_dout_sop, o_dout_eop    : first / last emitted pixel of a frame
//   o_frame_cnt               : completed frames (wraps)
//   o_err_line, o_err_frame   : one-cycle error pulses
// Build option: define CAPTURE_CROP_EN to emit only the X0/Y0/WIN_W/WIN_H
// window; otherwise the full H_PIX x V_LINES frame is emitted.
module cmos_capture_win
  import cmos_cap_pkg::*;
#(
  parameter int DIN_W         = 8,
  parameter int BYTES_PER_PIX = 2,
  parameter int H_PIX         = 1280,
  parameter int V_LINES       = 720,
  parameter int SKIP_FRAMES   = 10,
  parameter int X0            = 0,
  parameter int Y0            = 0,
  parameter int WIN_W         = 1280,
  parameter int WIN_H         = 720
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_vsync,
  input  logic                           i_href,
  input  logic [DIN_W-1:0]               i_din,
  input  logic                           i_enable,
  output logic [DIN_W*BYTES_PER_PIX-1:0] o_dout,
  output logic                           o_dout_vld,
  output logic                           o_dout_sop,
  output logic                           o_dout_eop,
  output logic [15:0]                    o_frame_cnt,
  output logic                           o_err_line,
  output logic                           o_err_frame
);
  localparam int XW = cnt_w(H_PIX);
  localparam int YW = cnt_w(V_LINES);
  localparam int SW = cnt_w(SKIP_FRAMES);

`ifdef CAPTURE_CROP_EN
  localparam bit CROP_ON = 1'b1;
`else
  localparam bit CROP_ON = 1'b0;
`endif

  localparam logic [XW-1:0] WX0  = XW'(CROP_ON ? X0 : 0);
  localparam logic [XW-1:0] WXN  = XW'(CROP_ON ? WIN_W : H_PIX);
  localparam logic [XW-1:0] WX1  = XW'(CROP_ON ? X0 + WIN_W - 1 : H_PIX - 1);
  localparam logic [YW-1:0] WY0  = YW'(CROP_ON ? Y0 : 0);
  localparam logic [YW-1:0] WYN  = YW'(CROP_ON ? WIN_H : V_LINES);
  localparam logic [YW-1:0] WY1  = YW'(CROP_ON ? Y0 + WIN_H - 1 : V_LINES - 1);
  localparam logic [XW-1:0] XEND = XW'(H_PIX);
  localparam logic [XW-1:0] XMAX = XW'(H_PIX + 1);
  localparam logic [YW-1:0] YEND = YW'(V_LINES);
  localparam logic [YW-1:0] YMAX = YW'(V_LINES + 1);
  localparam logic [SW-1:0] SKIPN = SW'(SKIP_FRAMES);

  logic             r_vs, r_vs_d, r_hr, r_hr_d;
  logic [DIN_W-1:0] r_din;
  logic             w_vs_rise, w_vs_fall, w_hr_rise, w_hr_fall;
  cap_state_e       r_state, w_next;
  logic [XW-1:0]    r_x, w_dx;
  logic [YW-1:0]    r_y, w_dy;
  logic [SW-1:0]    r_skip;
  logic             r_eop_seen, w_skip_done;
  logic             w_keep, w_sop, w_eop, w_err_line, w_err_frame;
  logic             w_done, w_mid;
  logic             r_sop, r_eop, r_err_line, r_err_frame;
  logic [15:0]      r_fcnt;

  assign w_vs_rise   = r_vs & ~r_vs_d;
  assign w_vs_fall   = ~r_vs & r_vs_d;
  assign w_hr_rise   = r_hr & ~r_hr_d;
  assign w_hr_fall   = ~r_hr & r_hr_d;
  assign w_skip_done = (r_skip >= SKIPN);

  cmos_pix_pack #(.DIN_W(DIN_W), .BYTES_PER_PIX(BYTES_PER_PIX)) u_pack (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_href(r_hr), .i_href_rise(w_hr_rise),
    .i_din(r_din), .i_keep(w_keep), .o_done(w_done), .o_mid(w_mid),
    .o_pix(o_dout), .o_vld(o_dout_vld)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:          if (i_enable) w_next = WAIT_VS;
      WAIT_VS, SKIP: begin
        if (w_vs_rise && !i_enable)      w_next = IDLE;
        else if (w_vs_fall && w_skip_done) w_next = ACTIVE;
        else if (w_vs_fall)               w_next = SKIP;
      end
      ACTIVE:        if (w_vs_rise) w_next = i_enable ? WAIT_VS : IDLE;
      default:       w_next = IDLE;
    endcase
  end

  // Window test by offset: x-X0 wraps large when x<X0, so one compare suffices.
  always_comb begin
    w_dx        = r_x - WX0;
    w_dy        = r_y - WY0;
    w_keep      = (r_state == ACTIVE) && (r_x < XEND) && (r_y < YEND) &&
                  (w_dx < WXN) && (w_dy < WYN);
    w_sop       = w_keep && (r_x == WX0) && (r_y == WY0);
    w_eop       = w_keep && (r_x == WX1) && (r_y == WY1);
    w_err_line  = (r_state == ACTIVE) && w_hr_fall && (r_y < YEND) &&
                  ((r_x != XEND) || w_mid);
    w_err_frame = (r_state == ACTIVE) && w_vs_rise && !r_eop_seen;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vs <= 1'b0; r_vs_d <= 1'b0; r_hr <= 1'b0; r_hr_d <= 1'b0;
      r_din       <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_skip      <= '0;
      r_eop_seen  <= 1'b0;
      r_sop       <= 1'b0;
      r_eop       <= 1'b0;
      r_err_line  <= 1'b0;
      r_err_frame <= 1'b0;
      r_fcnt      <= '0;
    end else begin
      r_vs <= i_vsync; r_vs_d <= r_vs;
      r_hr <= i_href;  r_hr_d <= r_hr;
      r_din <= i_din;
      if (w_hr_fall)                     r_x <= '0;
      else if (w_done && r_x != XMAX)    r_x <= r_x + XW'(1);
      if (w_vs_fall)                     r_y <= '0;
      else if (w_hr_fall && r_y != YMAX) r_y <= r_y + YW'(1);
      if (r_state == IDLE) r_skip <= '0;
      else if (w_vs_fall && (r_state == WAIT_VS || r_state == SKIP) && !w_skip_done)
        r_skip <= r_skip + SW'(1);
      if (r_state != ACTIVE)    r_eop_seen <= 1'b0;
      else if (w_done && w_eop) r_eop_seen <= 1'b1;
      r_sop       <= w_done & w_sop;
      r_eop       <= w_done & w_eop;
      r_err_line  <= w_err_line;
      r_err_frame <= w_err_frame;
      if (r_eop) r_fcnt <= r_fcnt + 16'd1;
    end
  end

  assign o_dout_sop  = r_sop;
  assign o_dout_eop  = r_eop;
  assign o_frame_cnt = r_fcnt;
  assign o_err_line  = r_err_line;
  assign o_err_frame = r_err_frame;

endmodule

// File: tb/tb_cmos_capture_win.sv
// Bench for cmos_capture_win on a 4x3, 2-byte-per-pixel frame, SKIP_FRAMES=2.
// Byte at (line l, byte b) is l*8+b, so pixel (x,y) = {y*8+2x, y*8+2x+1}.
// Crop parameters are always passed; they only matter with CAPTURE_CROP_EN.
module tb_cmos_capture_win;
  import cmos_cap_pkg::*;

  logic        clk = 1'b0, rst_n = 1'b0, vsync = 1'b1, href = 1'b0, enable = 1'b0;
  logic [7:0]  din = '0;
  logic [15:0] dout, fcnt;
  logic        vld, sop, eop, errl_o, errf_o;

  always #5 clk = ~clk;

  cmos_capture_win #(
    .DIN_W(8), .BYTES_PER_PIX(2), .H_PIX(4), .V_LINES(3), .SKIP_FRAMES(2),
    .X0(1), .Y0(1), .WIN_W(2), .WIN_H(2)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_vsync(vsync), .i_href(href), .i_din(din),
    .i_enable(enable), .o_dout(dout), .o_dout_vld(vld), .o_dout_sop(sop),
    .o_dout_eop(eop), .o_frame_cnt(fcnt), .o_err_line(errl_o), .o_err_frame(errf_o)
  );

`ifdef CAPTURE_CROP_EN
  localparam int          FULL_N = 4,  TRUNC_N = 4, ABORT_N = 0, ABORT_SOP = 0;
  localparam logic [15:0] FULL_F = 16'h0A0B, FULL_P2 = 16'h0C0D, FULL_L = 16'h1415;
`else
  localparam int          FULL_N = 12, TRUNC_N = 11, ABORT_N = 5, ABORT_SOP = 1;
  localparam logic [15:0] FULL_F = 16'h0001, FULL_P2 = 16'h0203, FULL_L = 16'h1617;
`endif
  localparam logic [15:0] ABORT_L = 16'h0809;

  typedef struct {
    int nb0, nb1, nb2, nb3, abort;
    int npix; logic [15:0] first, p2, last;
    int sop, eop, errl, errf, fd;
  } vec_t;
  vec_t vt[7];

  int passed = 0, total = 0;
  int npix, sop_cnt, sop_idx, eop_cnt, eop_idx, errl, errf;
  logic [15:0] px[16];
  logic [15:0] eop_val;

  always @(negedge clk) begin
    if (vld) begin
      if (npix < 16) px[npix] = dout;
      npix++;
      if (sop) begin sop_cnt++; sop_idx = npix; end
      if (eop) begin eop_cnt++; eop_idx = npix; eop_val = dout; end
    end
    if (errl_o) errl++;
    if (errf_o) errf++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic clr();
    npix = 0; sop_cnt = 0; sop_idx = 0; eop_cnt = 0; eop_idx = 0;
    errl = 0; errf = 0; eop_val = '0;
    for (int i = 0; i < 16; i++) px[i] = '0;
  endtask

  task automatic put(input logic vs, input logic hr, input logic [7:0] d);
    vsync = vs; href = hr; din = d;
    @(posedge clk); #1;
  endtask

  // One frame: vsync fall, lines of nb bytes, vsync rise. abort>0 raises
  // vsync (href still high) after that many bytes; drop>=0 clears enable
  // after that many bytes.
  task automatic send_frame(input int nb0, nb1, nb2, nb3, abort, drop);
    int nb[4];
    int sent;
    bit ab;
    nb = '{nb0, nb1, nb2, nb3};
    sent = 0; ab = 1'b0;
    put(0, 0, 0); put(0, 0, 0);
    for (int l = 0; l < 4 && !ab; l++) begin
      for (int b = 0; b < nb[l]; b++) begin
        if (sent == drop) enable = 1'b0;
        if (abort > 0 && sent == abort) begin
          put(1, 1, 8'(l*8 + b)); put(1, 1, 8'(l*8 + b + 1)); put(1, 0, 0);
          ab = 1'b1;
          break;
        end
        put(0, 1, 8'(l*8 + b));
        sent++;
      end
      if (!ab && nb[l] > 0) repeat (3) put(0, 0, 0);
    end
    if (!ab) put(1, 0, 0);
    repeat (6) put(1, 0, 0);
  endtask

  task automatic run_vec(input vec_t v, input int drop, input string tag);
    logic [15:0] f0, fd;
    int li;
    clr();
    f0 = fcnt;
    send_frame(v.nb0, v.nb1, v.nb2, v.nb3, v.abort, drop);
    fd = fcnt - f0;
    li = (npix > 0 && npix <= 16) ? npix - 1 : 0;
    chk({tag, ".npix"}, npix, v.npix);
    if (v.npix > 0) begin
      chk({tag, ".first"}, px[0], v.first);
      chk({tag, ".last"}, px[li], v.last);
    end
    if (v.npix > 1) chk({tag, ".pix2"}, px[1], v.p2);
    chk({tag, ".sop_cnt"}, sop_cnt, v.sop);
    chk({tag, ".eop_cnt"}, eop_cnt, v.eop);
    if (v.sop > 0) chk({tag, ".sop_pos"}, sop_idx, 1);
    if (v.eop > 0) begin
      chk({tag, ".eop_pos"}, eop_idx, npix);
      chk({tag, ".eop_pix"}, eop_val, v.last);
    end
    chk({tag, ".err_line"}, errl, v.errl);
    chk({tag, ".err_frame"}, errf, v.errf);
    chk({tag, ".fcnt_delta"}, fd, v.fd);
  endtask

  initial begin
    vt[0] = '{8, 8, 8, 0, 0,  0, 16'h0, 16'h0, 16'h0, 0, 0, 0, 0, 0};
    vt[1] = '{8, 8, 8, 0, 0,  0, 16'h0, 16'h0, 16'h0, 0, 0, 0, 0, 0};
    vt[2] = '{8, 8, 8, 0, 0,  FULL_N, FULL_F, FULL_P2, FULL_L, 1, 1, 0, 0, 1};
    vt[3] = '{8, 7, 8, 0, 0,  TRUNC_N, FULL_F, FULL_P2, FULL_L, 1, 1, 1, 0, 1};
    vt[4] = '{8, 8, 8, 0, 10, ABORT_N, 16'h0001, 16'h0203, ABORT_L, ABORT_SOP, 0, 0, 1, 0};
    vt[5] = '{8, 8, 8, 5, 0,  FULL_N, FULL_F, FULL_P2, FULL_L, 1, 1, 0, 0, 1};
    vt[6] = '{8, 8, 8, 0, 0,  FULL_N, FULL_F, FULL_P2, FULL_L, 1, 1, 0, 0, 1};
    clr();

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.dout", dout, 0);
    chk("rst.flags", {vld, sop, eop, errl_o, errf_o}, 0);
    chk("rst.fcnt", fcnt, 0);
    chk("rst.state", dut.r_state, IDLE);
    @(posedge clk); #1;
    rst_n = 1'b1; enable = 1'b1;
    repeat (3) put(1, 0, 0);

    for (int i = 0; i < 7; i++) run_vec(vt[i], -1, $sformatf("v%0d", i));
    chk("table.fcnt", fcnt, 4);

    // Async reset mid-line while capturing
    clr();
    put(0, 0, 0); put(0, 0, 0);
    for (int b = 0; b < 5; b++) put(0, 1, 8'(b));
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid.dout", dout, 0);
    chk("rstmid.flags", {vld, sop, eop, errl_o, errf_o}, 0);
    chk("rstmid.fcnt", fcnt, 0);
    put(0, 1, 5); put(0, 1, 6);
    rst_n = 1'b1;
    clr();
    put(0, 1, 7);
    repeat (3) put(0, 0, 0);
    for (int l = 1; l < 3; l++) begin
      for (int b = 0; b < 8; b++) put(0, 1, 8'(l*8 + b));
      repeat (3) put(0, 0, 0);
    end
    repeat (7) put(1, 0, 0);
    chk("rstmid.tail_npix", npix, 0);
    chk("rstmid.tail_errs", errl + errf, 0);
    run_vec(vt[0], -1, "post_rst0");
    run_vec(vt[1], -1, "post_rst1");
    run_vec(vt[2], -1, "post_rst2");
    chk("post_rst.fcnt", fcnt, 1);

    // Enable dropped mid-frame: frame completes, then IDLE
    run_vec(vt[2], 3, "endrop");
    chk("endrop.state", dut.r_state, IDLE);
    run_vec(vt[0], -1, "disabled");
    chk("disabled.state", dut.r_state, IDLE);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cmos_capture_win.md
CMOS_CAPTURE_WIN -- requirements
Module: cmos_capture_win

Interface
REQ-001 Parameter DIN_W, default 8: camera byte width.
REQ-002 Parameter BYTES_PER_PIX, default 2: bytes per pixel; legal values are 1 to 4.
REQ-003 Parameter H_PIX, default 1280: pixels per active line.
REQ-004 Parameter V_LINES, default 720: active lines per frame.
REQ-005 Parameter SKIP_FRAMES, default 10: frames discarded after enable rises.
REQ-006 Parameters X0/Y0/WIN_W/WIN_H, defaults 0/0/1280/720: crop window in pixels and lines.
REQ-007 clk  in  1  pixel clock; single clock domain.
REQ-008 rst_n  in  1  asynchronous, active-low reset.
REQ-009 vsync  in  1  frame sync; high marks blanking.
REQ-010 href  in  1  line-valid qualifier for din.
REQ-011 din  in  DIN_W  camera byte.
REQ-012 enable  in  1  capture enable.
REQ-013 dout  out  DIN_W*BYTES_PER_PIX  packed pixel.
REQ-014 dout_vld  out  1  pixel strobe.
REQ-015 dout_sop / dout_eop  out  1 each  first and last emitted pixel of a frame.
REQ-016 frame_cnt  out  16  count of completed frames; wraps 0xFFFF->0.
REQ-017 err_line / err_frame  out  1 each  single-cycle error pulses.

Function
REQ-018 vsync, href and din SHALL be registered once; all decisions use the registered copies.
REQ-019 FSM states: IDLE, WAIT_VS, SKIP, ACTIVE.
- IDLE->WAIT_VS on enable=1.
- WAIT_VS->SKIP on a vsync falling edge while the skip counter is below SKIP_FRAMES.
- WAIT_VS->ACTIVE on a vsync falling edge once SKIP_FRAMES frames have elapsed.
REQ-020 In SKIP, each vsync falling edge SHALL increment the skip counter; no pixels are emitted.
REQ-021 Bytes SHALL be packed MSB-first. The first byte of a pixel goes to dout[top DIN_W bits].
REQ-022 The byte phase SHALL reset to 0 on every href rising edge.
REQ-023 dout_vld SHALL assert 2 clk cycles after the last byte of a pixel is presented on din.
REQ-024 dout_sop SHALL accompany the first emitted pixel of the frame and dout_eop the last. Both are qualified by dout_vld.
REQ-025 Pixel x and line y counters SHALL run from 0.
- x resets on each href falling edge.
- y increments on each href falling edge and resets on the vsync falling edge.
REQ-026 A line ending with x != H_PIX, or a line that is mid-pixel at href fall, SHALL pulse err_line. The partial pixel is discarded. y still increments.
REQ-027 A vsync rise in ACTIVE before the eop pixel SHALL pulse err_frame and return to WAIT_VS. No eop is issued and frame_cnt is unchanged.
REQ-028 Lines with y >= V_LINES SHALL be ignored and produce no error.
REQ-029 frame_cnt SHALL increment in the cycle after dout_eop.
REQ-030 enable=0 SHALL take effect only at the next vsync rise; the current frame completes, then the FSM goes to IDLE.
REQ-031 When enable=0 and vsync rise coincide, the frame-end bookkeeping SHALL be applied first, then the FSM goes to IDLE.

Reset
REQ-032 While rst_n=0:
- all outputs are 0 and the FSM is in IDLE;
- the counters, skip counter and byte phase are cleared.
REQ-033 Reset deassertion mid-line SHALL NOT emit pixels until a full vsync falling edge has been seen.

Configuration
REQ-034 Macro CAPTURE_CROP_EN.
- When defined: only pixels with X0<=x<X0+WIN_W and Y0<=y<Y0+WIN_H are emitted. sop/eop refer to the window corners (X0,Y0) and (X0+WIN_W-1,Y0+WIN_H-1).
- When undefined: the window parameters are ignored and the full H_PIX x V_LINES frame is emitted.

Structure
REQ-035 Package cmos_cap_pkg SHALL hold:
- the FSM state typedef;
- counter-width constants (derived via $clog2 of H_PIX and V_LINES);
- a byte-phase width constant.
REQ-036 Sub-module cmos_pix_pack SHALL implement byte packing (REQ-021/022) and emit a packed pixel with a strobe.

Verification
REQ-037 SKIP_FRAMES=2, 4x3 frame, bytes 0x00..0x17:
- frames 1-2 produce no dout_vld;
- frame 3 produces 12 pixels, the first being 0x0001, with sop on that pixel and eop on pixel 12 (0x1617);
- frame_cnt=1 afterwards.
REQ-038 Line 1 of a 4x3 frame truncated to 7 bytes -> one err_line pulse, 3 pixels emitted for that line, eop still on the last pixel of line 2.
REQ-039 vsync raised after 5 of 12 pixels -> err_frame pulse, no eop, frame_cnt unchanged; the next full frame is captured normally.
REQ-040 CAPTURE_CROP_EN with X0=1, Y0=1, WIN_W=2, WIN_H=2 on a 4x3 frame -> exactly 4 pixels, at (1,1), (2,1), (1,2), (2,2); sop at (1,1), eop at (2,2).
REQ-041 rst_n pulsed low mid-frame -> all outputs 0 in the same cycle; no dout_vld until after the next vsync fall plus SKIP_FRAMES frames.
REQ-042 enable dropped mid-frame -> current frame completes with eop; no pixels thereafter; the FSM reads IDLE after the vsync rise.
